// File: rtl/mar_burst_if.sv
// Handshake and address bus between the datapath/memory controller and the
// burst address register.
interface mar_burst_if #(
  parameter int AW = 32,
  parameter int CW = 4
);
  logic [AW-1:0] Ds;
  logic          MARld;
  logic [1:0]    mode;
  logic [CW-1:0] burst_len;
  logic          start;
  logic          MFC;
  logic [AW-1:0] outToRAMAddress;
  logic          MOV;
  logic          busy;
  logic          done;
  logic          align_err;

  modport master (
    output Ds, MARld, mode, burst_len, start, MFC,
    input  outToRAMAddress, MOV, busy, done, align_err
  );

  modport slave (
    input  Ds, MARld, mode, burst_len, start, MFC,
    output outToRAMAddress, MOV, busy, done, align_err
  );
endinterface

// File: rtl/mar_burst.sv
// Memory address register with burst sequencing: issues 1..2^CW beats at a
// size-dependent stride, one beat per MFC acknowledge.
module mar_burst #(
  parameter int AW = 32,
  parameter int CW = 4
) (
  input logic       clk,
  input logic       reset,
  mar_burst_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t        state;
  logic [AW-1:0] addr;
  logic [CW-1:0] cnt;
  logic [1:0]    mode_q;
  logic          mov_q, busy_q, done_q, err_q;

  logic [AW-1:0] src;
  logic          aligned;

  function automatic logic [AW-1:0] stride_of(input logic [1:0] m);
    stride_of = AW'(1) << m;
  endfunction

  // A same-cycle MARld means the freshly loaded Ds is the burst base.
  always_comb begin
    src     = bus.MARld ? bus.Ds : addr;
    aligned = ((src & (stride_of(bus.mode) - AW'(1))) == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      addr   <= '0;
      cnt    <= '0;
      mode_q <= 2'b00;
      mov_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.MARld) addr <= bus.Ds;
          if (bus.start) begin
            if (aligned) begin
              mode_q <= bus.mode;
              cnt    <= bus.burst_len;
              err_q  <= 1'b0;
              mov_q  <= 1'b1;
              busy_q <= 1'b1;
              state  <= ISSUE;
            end else begin
              err_q  <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (bus.MFC) begin
            if (cnt != '0) begin
              // Stride add wraps naturally at 2^AW.
              addr <= addr + stride_of(mode_q);
              cnt  <= cnt - CW'(1);
            end else begin
              mov_q  <= 1'b0;
              busy_q <= 1'b0;
              done_q <= 1'b1;
              state  <= DONE;
            end
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.outToRAMAddress = addr;
  assign bus.MOV             = mov_q;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.align_err       = err_q;

endmodule

// File: tb/tb_mar_burst.sv
// Self-checking bench for mar_burst: directed table, hand-written corner
// sequences and randomized bursts against an arithmetic address model.
module tb_mar_burst;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mar_burst_if #(.AW(32), .CW(4)) bus ();
  mar_burst #(.AW(32), .CW(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one burst and compares every cycle against base + k*stride.
  task automatic run_burst(input logic [31:0] base, input logic [1:0] mode,
                           input logic [3:0] len, input int wmin, input int wmax,
                           input bit same, output logic [31:0] last, output logic err);
    logic [31:0] stride, exp;
    bit misal;
    int w;
    stride = 32'd1 << mode;
    misal  = (base % stride) != 0;
    if (!same) begin
      bus.MARld = 1'b1; bus.Ds = base;
      tick();
      bus.MARld = 1'b0; bus.Ds = $urandom;
    end else begin
      bus.MARld = 1'b1; bus.Ds = base;
    end
    bus.start = 1'b1; bus.mode = mode; bus.burst_len = len;
    tick();
    bus.start = 1'b0; bus.MARld = 1'b0; bus.Ds = $urandom;
    bus.mode = 2'($urandom); bus.burst_len = 4'($urandom);
    err = bus.align_err;
    last = bus.outToRAMAddress;
    if (misal) begin
      check("misal_err", bus.align_err, 1);
      check("misal_mov", bus.MOV, 0);
      check("misal_busy", bus.busy, 0);
      check("misal_addr", bus.outToRAMAddress, base);
      tick();
      check("misal_idle_mov", bus.MOV, 0);
      return;
    end
    check("start_err_clr", bus.align_err, 0);
    for (int k = 0; k <= int'(len); k++) begin
      exp = base + 32'(k) * stride;
      w = $urandom_range(wmax, wmin);
      for (int c = 0; c <= w; c++) begin
        check("beat_addr", bus.outToRAMAddress, exp);
        check("beat_mov", bus.MOV, 1);
        check("beat_busy", bus.busy, 1);
        check("beat_done", bus.done, 0);
        bus.MFC = (c == w);
        tick();
      end
      bus.MFC = 1'b0;
    end
    check("done_pulse", bus.done, 1);
    check("done_mov", bus.MOV, 0);
    check("done_busy", bus.busy, 0);
    last = bus.outToRAMAddress;
    err = bus.align_err;
    bus.MFC = 1'($urandom);
    tick();
    bus.MFC = 1'b0;
    check("done_one_cycle", bus.done, 0);
    check("idle_mov", bus.MOV, 0);
    check("idle_addr_hold", bus.outToRAMAddress, last);
  endtask

  typedef struct {
    logic [31:0] base;
    logic [1:0]  mode;
    logic [3:0]  len;
    logic        exp_err;
    logic [31:0] exp_last;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [31:0] last, b;
    logic err;
    logic [1:0] m;

    vecs.push_back('{32'h0000_0100, 2'b10, 4'd3, 1'b0, 32'h0000_010C});
    vecs.push_back('{32'h0000_0102, 2'b10, 4'd0, 1'b1, 32'h0000_0102});
    vecs.push_back('{32'h0000_2002, 2'b01, 4'd1, 1'b0, 32'h0000_2004});
    vecs.push_back('{32'hFFFF_FFF8, 2'b11, 4'd1, 1'b0, 32'h0000_0000});
    vecs.push_back('{32'hFFFF_FFFC, 2'b10, 4'd1, 1'b0, 32'h0000_0000});
    vecs.push_back('{32'h0000_0007, 2'b00, 4'd2, 1'b0, 32'h0000_0009});
    vecs.push_back('{32'h0000_0010, 2'b11, 4'd15, 1'b0, 32'h0000_0088});
    vecs.push_back('{32'h0000_0003, 2'b01, 4'd0, 1'b1, 32'h0000_0003});

    reset = 1'b1;
    bus.Ds = 32'hA5A5_A5A5; bus.MARld = 1'b1; bus.mode = 2'b00;
    bus.burst_len = '0; bus.start = 1'b1; bus.MFC = 1'b1;
    tick(); tick();
    check("rst_addr", bus.outToRAMAddress, 0);
    check("rst_mov", bus.MOV, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.align_err, 0);
    reset = 1'b0; bus.MARld = 1'b0; bus.start = 1'b0; bus.MFC = 1'b0;
    tick();

    // MFC in IDLE must not move the address.
    bus.MFC = 1'b1;
    tick(); tick();
    bus.MFC = 1'b0;
    check("idle_mfc_ignored", bus.outToRAMAddress, 0);
    check("idle_mfc_mov", bus.MOV, 0);

    foreach (vecs[i]) begin
      run_burst(vecs[i].base, vecs[i].mode, vecs[i].len, 0, 0, 1'b0, last, err);
      check($sformatf("vec%0d_err", i), err, vecs[i].exp_err);
      check($sformatf("vec%0d_last", i), last, vecs[i].exp_last);
    end

    // Wait states: 0x2002 and 0x2004 each held for four cycles.
    run_burst(32'h0000_2002, 2'b01, 4'd1, 3, 3, 1'b0, last, err);
    check("wait_last", last, 32'h0000_2004);

    // Sticky error, then cleared by an aligned start from the held address.
    run_burst(32'h0000_0102, 2'b10, 4'd0, 0, 0, 1'b0, last, err);
    check("sticky_err_set", bus.align_err, 1);
    bus.start = 1'b1; bus.mode = 2'b01; bus.burst_len = 4'd0;
    tick();
    bus.start = 1'b0;
    check("err_cleared", bus.align_err, 0);
    check("held_addr_used", bus.outToRAMAddress, 32'h0000_0102);
    check("held_start_mov", bus.MOV, 1);
    bus.MFC = 1'b1; tick(); bus.MFC = 1'b0;
    check("held_done", bus.done, 1);
    tick();

    // Same-cycle MARld+start, then MARld/start pulsed during ISSUE.
    bus.MARld = 1'b1; bus.Ds = 32'h0000_0013; tick();
    bus.Ds = 32'h0000_0040; bus.start = 1'b1; bus.mode = 2'b00; bus.burst_len = 4'd1;
    tick();
    bus.MARld = 1'b0; bus.start = 1'b0;
    check("same_cycle_base", bus.outToRAMAddress, 32'h0000_0040);
    check("same_cycle_mov", bus.MOV, 1);
    bus.MARld = 1'b1; bus.Ds = 32'hDEAD_0000; bus.start = 1'b1; bus.mode = 2'b11;
    tick();
    bus.MARld = 1'b0; bus.start = 1'b0;
    check("issue_marld_ignored", bus.outToRAMAddress, 32'h0000_0040);
    bus.MFC = 1'b1; tick();
    check("issue_stride_kept", bus.outToRAMAddress, 32'h0000_0041);
    tick(); bus.MFC = 1'b0;
    check("issue_done", bus.done, 1);
    check("issue_done_addr", bus.outToRAMAddress, 32'h0000_0041);
    tick();

    // Reset during beat 2 of a 4-beat word burst.
    bus.MARld = 1'b1; bus.Ds = 32'h0000_0100; bus.start = 1'b1;
    bus.mode = 2'b10; bus.burst_len = 4'd3;
    tick();
    bus.MARld = 1'b0; bus.start = 1'b0;
    bus.MFC = 1'b1; tick();
    check("pre_rst_beat2", bus.outToRAMAddress, 32'h0000_0104);
    reset = 1'b1; bus.MARld = 1'b1; bus.start = 1'b1;
    tick();
    reset = 1'b0; bus.MARld = 1'b0; bus.start = 1'b0;
    check("midrst_addr", bus.outToRAMAddress, 0);
    check("midrst_mov", bus.MOV, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_done", bus.done, 0);
    check("midrst_err", bus.align_err, 0);
    for (int c = 0; c < 4; c++) begin
      tick();
      check("postrst_mfc_addr", bus.outToRAMAddress, 0);
      check("postrst_mfc_done", bus.done, 0);
      check("postrst_mfc_mov", bus.MOV, 0);
    end
    bus.MFC = 1'b0;

    // Randomized bursts; half the bases are forced aligned.
    for (int r = 0; r < 60; r++) begin
      m = 2'($urandom);
      b = $urandom;
      if ($urandom_range(1, 0) == 1) b = b & ~((32'd1 << m) - 32'd1);
      if ($urandom_range(3, 0) == 0) b = b | 32'hFFFF_FF00;
      run_burst(b, m, 4'($urandom), 0, 2, 1'($urandom), last, err);
      check("rand_err", err, (b % (32'd1 << m)) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mar_burst.md
MAR_BURST -- requirements
Module: mar_burst

Parameters
REQ-001 SHALL provide parameter AW, default 32, memory address width in bits.
REQ-002 SHALL provide parameter CW, default 4, burst-length field width; maximum burst is 2^CW beats.

Interface
REQ-003 SHALL have clk input 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have reset input 1: synchronous, active-high reset.
REQ-005 SHALL have Ds input AW: address source from the datapath bus.
REQ-006 SHALL have MARld input 1: load Ds into the address register.
REQ-007 SHALL have mode input 2: access size; 00 byte, 01 halfword, 10 word, 11 doubleword.
REQ-008 SHALL have burst_len input CW: number of beats minus one.
REQ-009 SHALL have start input 1: begin a burst from the current address.
REQ-010 SHALL have MFC input 1: memory function complete; acknowledges the current beat.
REQ-011 SHALL have outToRAMAddress output AW: address presented to RAM.
REQ-012 SHALL have MOV output 1: memory operation valid; a beat is outstanding.
REQ-013 SHALL have busy output 1: a burst is in progress.
REQ-014 SHALL have done output 1: one-cycle pulse after the last beat is acknowledged.
REQ-015 SHALL have align_err output 1: sticky flag; start was attempted with a misaligned address.

Function
REQ-016 The block SHALL implement three states: IDLE, ISSUE and DONE.
REQ-017 Stride SHALL be 1, 2, 4 or 8 for mode 00, 01, 10 or 11.
- An address is aligned when it is a multiple of the stride.
REQ-018 In IDLE, MARld=1 SHALL load Ds into outToRAMAddress on the clock edge; MARld=0 holds the address.
REQ-019 Address source for start in IDLE:
- start=1 with MARld=0 SHALL use the held address.
- start=1 with MARld=1 SHALL load Ds and use Ds for both the alignment check and the burst.
REQ-020 Start in IDLE with an aligned address SHALL:
- latch mode;
- load the beat counter with burst_len;
- clear align_err;
- enter ISSUE on the next edge.
REQ-021 Start in IDLE with a misaligned address SHALL set align_err, stay in IDLE, and leave MOV, busy and done at 0.
REQ-022 In ISSUE, MOV and busy SHALL be 1, and outToRAMAddress SHALL be stable until MFC=1 is sampled.
REQ-023 MFC=1 in ISSUE with beat counter nonzero SHALL:
- add the stride to the address, modulo 2^AW (0xFFFFFFFC + 4 = 0x00000000, no error);
- decrement the counter;
- remain in ISSUE.
- MOV stays 1 with no idle cycle between beats.
REQ-024 MFC=1 in ISSUE with beat counter zero SHALL enter DONE; the address holds at the last beat address.
REQ-025 DONE SHALL last exactly one cycle:
- done=1, MOV=0, busy=0;
- then return to IDLE.
REQ-026 Latency: the first beat address SHALL appear with MOV=1 in the cycle after the start edge; done SHALL be asserted the cycle after the final MFC.
REQ-027 MARld, start, mode and burst_len SHALL be ignored in ISSUE and DONE.
REQ-028 MFC SHALL be ignored in IDLE and DONE.
REQ-029 The address register SHALL change only through:
- reset;
- MARld in IDLE;
- a beat acknowledge in ISSUE.

Reset
REQ-030 reset=1 at a clock edge SHALL force the following, regardless of state, including mid-burst:
- IDLE state;
- outToRAMAddress=0;
- MOV=0, busy=0, done=0, align_err=0;
- beat counter 0.
REQ-031 reset SHALL take priority over MARld, start and MFC sampled in the same cycle.
REQ-032 The outstanding beat SHALL be abandoned on reset; no done is issued for it.

Verification
REQ-033 Word burst:
- Stimulus: MARld=1 with Ds=0x00000100, then start with mode=10, burst_len=3, MFC=1 every cycle.
- Response: addresses 0x100, 0x104, 0x108, 0x10C on consecutive cycles with MOV=1; done one cycle after the 4th MFC; address holds at 0x10C.
REQ-034 Wait states:
- Stimulus: halfword burst, burst_len=1, base 0x2002, MFC held 0 for 3 cycles per beat.
- Response: 0x2002 held for 4 cycles, then 0x2004 held for 4 cycles; MOV=1 throughout; a single done pulse.
REQ-035 Misaligned start:
- Stimulus: start with mode=10 at address 0x00000102.
- Response: align_err=1, MOV=0, busy=0; a later aligned start clears align_err.
REQ-036 Address wrap:
- Stimulus: doubleword burst, burst_len=1, base 0xFFFFFFF8.
- Response: beats at 0xFFFFFFF8 then 0x00000000; no error.
REQ-037 Mid-burst reset:
- Stimulus: reset=1 during beat 2 of a 4-beat burst.
- Response: next cycle all outputs 0, state IDLE; MFC asserted afterwards has no effect.
REQ-038 Same-cycle MARld and start:
- Stimulus: MARld=1 and start=1 with Ds=0x40 and mode=00; separately, MARld pulsed during ISSUE.
- Response: the burst begins at 0x40; the MARld pulsed during ISSUE is ignored.
